// File: rtl/m65_kb_pkg.sv
// Shared types and scancode table for the MEGA65 matrix-to-scancode block.
// Optional typematic repeat is enabled by defining M65_TYPEMATIC_EN.
package m65_kb_pkg;

  localparam int NUM_KEYS_DEFAULT = 72;

  localparam int IDX_INSDEL  = 0;
  localparam int IDX_RETURN  = 1;
  localparam int IDX_CRSR_LR = 2;
  localparam int IDX_A       = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_LOOKUP,
    ST_EMIT,
    ST_GAP
  } state_e;

  // {ext, code}; code 0x00 marks an unmapped position
  localparam logic [8:0] SC_ROM [0:NUM_KEYS_DEFAULT-1] = '{
    9'h066, 9'h05A, 9'h174, 9'h083,
    9'h005, 9'h004, 9'h003, 9'h172,
    9'h026, 9'h01D, 9'h01C, 9'h025,
    9'h01A, 9'h01B, 9'h024, 9'h012,
    9'h02E, 9'h02D, 9'h023, 9'h036,
    9'h021, 9'h02B, 9'h02C, 9'h022,
    9'h03D, 9'h035, 9'h034, 9'h03E,
    9'h032, 9'h033, 9'h03C, 9'h02A,
    9'h046, 9'h043, 9'h03B, 9'h045,
    9'h03A, 9'h042, 9'h044, 9'h031,
    9'h055, 9'h04D, 9'h04B, 9'h04E,
    9'h049, 9'h04C, 9'h054, 9'h041,
    9'h05D, 9'h05B, 9'h052, 9'h16C,
    9'h059, 9'h000, 9'h00E, 9'h04A,
    9'h016, 9'h000, 9'h014, 9'h01E,
    9'h029, 9'h11F, 9'h015, 9'h076,
    9'h07E, 9'h00D, 9'h011, 9'h000,
    9'h001, 9'h078, 9'h000, 9'h000
  };

endpackage

// File: rtl/m65_scancode_rom.sv
// Registered matrix-index to {ext, code} lookup.
// One cycle of read latency; out-of-table indices read as unmapped.
module m65_scancode_rom
  import m65_kb_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEFAULT,
  parameter int AW       = $clog2(NUM_KEYS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  output logic [8:0]    data_o
);

  localparam int DEPTH =
    (NUM_KEYS < NUM_KEYS_DEFAULT) ? NUM_KEYS : NUM_KEYS_DEFAULT;

  // read the table one cycle after the address is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o <= '0;
    end else if (addr_i < AW'(DEPTH)) begin
      data_o <= SC_ROM[addr_i];
    end else begin
      data_o <= '0;
    end
  end

endmodule

// File: rtl/m65_matrix_to_scancode.sv
// Turns MEGA65 matrix frames into PS/2 set-2 style make/break events.
// Define M65_TYPEMATIC_EN to add held-key auto-repeat.
module m65_matrix_to_scancode
  import m65_kb_pkg::*;
#(
  parameter int NUM_KEYS   = NUM_KEYS_DEFAULT,
  parameter int GAP_CYCLES = 16
`ifdef M65_TYPEMATIC_EN
  , parameter int REPEAT_DELAY = 25_000_000
  , parameter int REPEAT_RATE  = 5_000_000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] matrix,
  input  logic                matrix_valid,
  output logic                kb_interrupt,
  output logic [7:0]          scancode,
  output logic                extended,
  output logic                released,
  output logic                busy,
  output logic                overrun
);

  localparam int IW = $clog2(NUM_KEYS);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_KEYS - 1);

  state_e              state_q;
  logic [NUM_KEYS-1:0] snap_q;
  logic [NUM_KEYS-1:0] prev_q;
  logic [IW-1:0]       idx_q;
  logic [GW-1:0]       gap_q;
  logic [8:0]          rom_data;
  logic                changed;
  logic                unmapped;
  logic                adv;

`ifdef M65_TYPEMATIC_EN
  logic          rep_vld_q;
  logic [IW-1:0] rep_idx_q;
  logic [8:0]    rep_code_q;
  logic [31:0]   rep_cnt_q;
  logic          rep_fire;

  assign rep_fire = rep_vld_q && (rep_cnt_q == '0) &&
                    (state_q == ST_IDLE) && !matrix_valid &&
                    !prev_q[rep_idx_q];
`endif

  m65_scancode_rom #(
    .NUM_KEYS (NUM_KEYS)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (idx_q),
    .data_o (rom_data)
  );

  assign changed  = snap_q[idx_q] != prev_q[idx_q];
  assign unmapped = rom_data[7:0] == 8'h00;
  assign busy     = state_q != ST_IDLE;
  assign overrun  = matrix_valid & busy;

  // step to the next index without spending an extra cycle
  always_comb begin
    adv = 1'b0;
    unique case (state_q)
      ST_SCAN:   adv = !changed;
      ST_LOOKUP: adv = unmapped;
      ST_GAP:    adv = gap_q == '0;
      default:   adv = 1'b0;
    endcase
  end

  // scan FSM with registered event outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      snap_q       <= '1;
      prev_q       <= '1;
      idx_q        <= '0;
      gap_q        <= '0;
      kb_interrupt <= 1'b0;
      scancode     <= 8'h00;
      extended     <= 1'b0;
      released     <= 1'b0;
`ifdef M65_TYPEMATIC_EN
      rep_vld_q    <= 1'b0;
      rep_idx_q    <= '0;
      rep_code_q   <= '0;
      rep_cnt_q    <= '0;
`endif
    end else begin
      kb_interrupt <= 1'b0;
`ifdef M65_TYPEMATIC_EN
      if (rep_vld_q && rep_cnt_q != '0)
        rep_cnt_q <= rep_cnt_q - 1'b1;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (matrix_valid) begin
            snap_q  <= matrix;
            idx_q   <= '0;
            state_q <= ST_SCAN;
          end
`ifdef M65_TYPEMATIC_EN
          if (rep_fire) begin
            kb_interrupt <= 1'b1;
            scancode     <= rep_code_q[7:0];
            extended     <= rep_code_q[8];
            released     <= 1'b0;
            rep_cnt_q    <= 32'(REPEAT_RATE - 1);
          end
`endif
        end
        ST_SCAN: begin
          if (changed)
            state_q <= ST_LOOKUP;
        end
        ST_LOOKUP: begin
          if (unmapped) begin
            prev_q[idx_q] <= snap_q[idx_q];
          end else begin
            state_q      <= ST_EMIT;
            kb_interrupt <= 1'b1;
            scancode     <= rom_data[7:0];
            extended     <= rom_data[8];
            released     <= snap_q[idx_q];
`ifdef M65_TYPEMATIC_EN
            rep_vld_q    <= !snap_q[idx_q];
            rep_idx_q    <= idx_q;
            rep_code_q   <= rom_data;
            rep_cnt_q    <= 32'(REPEAT_DELAY - 1);
`endif
          end
        end
        ST_EMIT: begin
          prev_q[idx_q] <= snap_q[idx_q];
          gap_q         <= GW'(GAP_CYCLES - 1);
          state_q       <= ST_GAP;
        end
        ST_GAP: begin
          if (!adv)
            gap_q <= gap_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (adv) begin
        if (idx_q == LAST_IDX) begin
          state_q <= ST_IDLE;
        end else begin
          idx_q   <= idx_q + 1'b1;
          state_q <= ST_SCAN;
        end
      end
    end
  end

endmodule

// File: tb/tb_m65_matrix_to_scancode.sv
// Self-checking bench for m65_matrix_to_scancode.
// Directed steps plus random frames against a per-frame event model.
module tb_m65_matrix_to_scancode;

  localparam int NK  = 72;
  localparam int GAP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] matrix = '1;
  logic          matrix_valid = 1'b0;
  logic          kb_interrupt;
  logic [7:0]    scancode;
  logic          extended;
  logic          released;
  logic          busy;
  logic          overrun;

  typedef struct {
    int         cyc;
    logic [7:0] sc;
    logic       ext;
    logic       rel;
  } ev_t;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  ev_t           got_q[$];
  ev_t           exp_q[$];
  logic [NK-1:0] mprev = '1;
  logic [7:0]    lastcode = 8'h00;
  int            keys[8] = '{0, 1, 2, 3, 7, 10, 15, 67};

  m65_matrix_to_scancode #(
    .NUM_KEYS     (NK),
    .GAP_CYCLES   (GAP)
`ifdef M65_TYPEMATIC_EN
    , .REPEAT_DELAY (100)
    , .REPEAT_RATE  (20)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .matrix       (matrix),
    .matrix_valid (matrix_valid),
    .kb_interrupt (kb_interrupt),
    .scancode     (scancode),
    .extended     (extended),
    .released     (released),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (kb_interrupt)
      got_q.push_back('{cyc, scancode, extended, released});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference key table for the keys this bench exercises
  function automatic logic [8:0] ref_code(input int i);
    case (i)
      0:       return 9'h066;
      1:       return 9'h05A;
      2:       return 9'h174;
      3:       return 9'h083;
      7:       return 9'h172;
      10:      return 9'h01C;
      15:      return 9'h012;
      default: return 9'h000;
    endcase
  endfunction

  // called at a negedge; sends f, waits for idle, checks events
  task automatic run_frame(input logic [NK-1:0] f, input string tag);
    int t;
    int t0;
    int n;
    logic [8:0] c;
    exp_q.delete();
    t = 0;
    for (int i = 0; i < NK; i++) begin
      if (f[i] == mprev[i]) begin
        t += 1;
      end else begin
        c = ref_code(i);
        if (c[7:0] == 8'h00) begin
          t += 2;
        end else begin
          exp_q.push_back('{t + 2, c[7:0], c[8], f[i]});
          t += GAP + 3;
        end
        mprev[i] = f[i];
      end
    end
    got_q.delete();
    matrix = f;
    matrix_valid = 1'b1;
    @(negedge clk);
    matrix_valid = 1'b0;
    t0 = cyc;
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy"}, n, t);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      chk({tag, " time"}, got_q[k].cyc - t0, exp_q[k].cyc);
      chk({tag, " code"}, got_q[k].sc, exp_q[k].sc);
      chk({tag, " ext"}, got_q[k].ext, exp_q[k].ext);
      chk({tag, " rel"}, got_q[k].rel, exp_q[k].rel);
    end
    if (exp_q.size() > 0)
      lastcode = exp_q[exp_q.size()-1].sc;
    chk({tag, " hold"}, scancode, lastcode);
  endtask

  initial begin : main
    logic [NK-1:0] fa;
    logic [NK-1:0] f;
    logic [NK-1:0] all1;
    int n;
    all1 = '1;

    repeat (3) @(negedge clk);
    chk("rst int", kb_interrupt, 0);
    chk("rst code", scancode, 0);
    chk("rst ext", extended, 0);
    chk("rst rel", released, 0);
    chk("rst busy", busy, 0);
    chk("rst ovr", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(all1, "idle frame");

    fa = all1;
    fa[10] = 1'b0;
    run_frame(fa, "A make");
    run_frame(all1, "A break");

    f = all1;
    f[2] = 1'b0;
    run_frame(f, "crsr make");
    run_frame(all1, "crsr break");

    f = all1;
    f[0] = 1'b0;
    f[1] = 1'b0;
    run_frame(f, "pair make");
    if (got_q.size() == 2)
      chk("pair spacing", got_q[1].cyc - got_q[0].cyc, GAP + 3);
    else
      chk("pair spacing n", got_q.size(), 2);
    run_frame(all1, "pair break");

    f = all1;
    f[67] = 1'b0;
    run_frame(f, "unmapped make");
    run_frame(all1, "unmapped break");

    // frame arriving mid-scan is dropped
    got_q.delete();
    matrix = fa;
    matrix_valid = 1'b1;
    @(negedge clk);
    matrix_valid = 1'b0;
    repeat (5) @(negedge clk);
    f = all1;
    f[0] = 1'b0;
    matrix = f;
    matrix_valid = 1'b1;
    #1;
    chk("overrun hi", overrun, 1);
    @(negedge clk);
    matrix_valid = 1'b0;
    #1;
    chk("overrun lo", overrun, 0);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("ovr idle", busy, 0);
    chk("ovr count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("ovr code", got_q[0].sc, 8'h1C);
      chk("ovr rel", got_q[0].rel, 0);
    end
    mprev[10] = 1'b0;
    lastcode = 8'h1C;
    run_frame(f, "resend");
    run_frame(all1, "clear");

    // reset during the gap after an A make
    got_q.delete();
    matrix = fa;
    matrix_valid = 1'b1;
    @(negedge clk);
    matrix_valid = 1'b0;
    n = 0;
    while (got_q.size() == 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("rst wait", got_q.size(), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid rst code", scancode, 0);
    chk("mid rst rel", released, 0);
    chk("mid rst int", kb_interrupt, 0);
    chk("mid rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mprev = '1;
    lastcode = 8'h00;
    repeat (5) @(negedge clk);
    chk("no partial", got_q.size(), 1);
    run_frame(fa, "A after rst");
    run_frame(all1, "A rel after rst");

    for (int r = 0; r < 12; r++) begin
      f = all1;
      foreach (keys[j])
        f[keys[j]] = 1'($urandom_range(0, 1));
      run_frame(f, $sformatf("rand%0d", r));
    end
    run_frame(all1, "rand clear");

`ifdef M65_TYPEMATIC_EN
    begin : typematic
      int m;
      run_frame(fa, "tm make");
      m = (got_q.size() > 0) ? got_q[0].cyc : 0;
      got_q.delete();
      repeat (70) @(negedge clk);
      chk("tm count", got_q.size(), 3);
      for (int k = 0; k < 3 && k < got_q.size(); k++) begin
        chk("tm time", got_q[k].cyc - m, 100 + 20 * k);
        chk("tm code", got_q[k].sc, 8'h1C);
        chk("tm rel", got_q[k].rel, 0);
      end
      run_frame(all1, "tm break");
      got_q.delete();
      repeat (200) @(negedge clk);
      chk("tm stop", got_q.size(), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/m65_matrix_to_scancode.md
Name: m65_matrix_to_scancode

Overview:
- Converts MEGA65 keyboard-matrix snapshots into a serial stream of PS/2 set-2 style key events.
- Output is scancode, extended flag, released flag and a one-cycle kb_interrupt strobe.
- Sits directly upstream of the ZX-Uno keyboard stage. It drives the nueva_tecla/kbcode/extended/released nets consumed by the special-function, pressed-status and scancode-to-Speccy translators.
- Event format, including bit-7 codes, is byte-identical to what a PS/2 receiver would deliver.

Parameters:
- NUM_KEYS, 72, number of matrix positions scanned (index = col*8 + row).
- GAP_CYCLES, 16, idle clocks enforced after every emitted event, so downstream translators finish processing.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- matrix  in  NUM_KEYS  current key state, active-low (0 = pressed)
- matrix_valid  in  1  one-cycle strobe: matrix holds a complete new frame
- kb_interrupt  out  1  one-cycle strobe: new event on scancode/extended/released
- scancode  out  8  PS/2 code of event key
- extended  out  1  key is an E0-prefixed code
- released  out  1  1 = break, 0 = make
- busy  out  1  high whenever state != IDLE
- overrun  out  1  one-cycle strobe: frame dropped because busy

Behaviour:
- Reset values: all outputs 0; internal prev[] all 1 (all released); state IDLE; idx 0.
- Reset mid-scan aborts immediately. No partial event is emitted after rst_n deasserts.
- Sub-module ROM: registered, 1-cycle read latency, data {ext, code[7:0]}. code 0x00 = unmapped.
- FSM:
  - IDLE: on matrix_valid, snap <= matrix; idx <= 0; go SCAN.
  - SCAN: if snap[idx] == prev[idx], go to ADVANCE. Otherwise drive rom_addr = idx and go LOOKUP.
  - LOOKUP: if code == 0x00, prev[idx] <= snap[idx] silently and go ADVANCE. Otherwise go EMIT.
  - EMIT: for one cycle, kb_interrupt = 1; scancode = code; extended = ext; released = snap[idx]; prev[idx] <= snap[idx]. Load gap counter with GAP_CYCLES and go GAP.
  - GAP: decrement the counter; at 0 go ADVANCE.
  - ADVANCE (combinational decision, no extra cycle): if idx == NUM_KEYS-1, go IDLE. Otherwise idx++ and go SCAN.
- Latency from a changed key's SCAN cycle to kb_interrupt: 2 clocks. Unchanged key: 1 clock per index.
- Event spacing: at least GAP_CYCLES+3 clocks between consecutive kb_interrupt pulses.
- scancode/extended/released hold their values until the next EMIT.
- Ordering: changes within a frame are emitted in ascending idx. A key's make and break are never both emitted from one frame.
- matrix_valid while busy: frame ignored, overrun pulses the same cycle, scan continues on the old snap. The next frame re-detects any still-differing keys, so no event is lost permanently.
- matrix_valid on the cycle ADVANCE returns to IDLE: counts as busy (dropped + overrun).
- Bit-7 codes (e.g. 0x83 F7) are emitted unchanged; downstream filters them.

Optional Feature:
- Macro M65_TYPEMATIC_EN.
- Enabled: tracks the last emitted make key. If it is still held (prev = 0) and no other event occurs for 500 ms, the block re-emits its make event every 100 ms while idle. Timing derives from parameters REPEAT_DELAY and REPEAT_RATE (clock counts). Any new event or its release cancels the repeat. A repeat only fires in IDLE.
- Disabled: no repeat logic, no extra parameters, make emitted once per press.

Decomposition:
- Package m65_kb_pkg holds:
  - NUM_KEYS_DEFAULT
  - FSM state enum
  - scancode ROM contents as a constant array (72 x 9 bits)
  - named index constants: IDX_INSDEL=0, IDX_RETURN=1, IDX_CRSR_LR=2, IDX_A=10
- One sub-module, m65_scancode_rom: registered lookup, idx -> {ext, code}.

Test Plan:
- Reset, then a frame with all 1s -> no kb_interrupt; busy high 72 clocks then low; all outputs 0.
- Frame with bit 10 = 0 (A) -> one pulse, scancode 0x1C, extended 0, released 0. Next all-1s frame -> 0x1C, released 1.
- Bit 2 = 0 (CRSR right) -> scancode 0x74, extended 1. Bits 0 and 1 pressed together -> 0x66 then 0x5A, pulses exactly GAP_CYCLES+3 clocks apart.
- matrix_valid pulsed while busy -> overrun 1 for one cycle, frame ignored. Resending the same frame when idle emits the pending changes.
- rst_n asserted during GAP after an A make -> outputs 0. Resending A pressed after reset re-emits 0x1C make because prev was cleared.
- M65_TYPEMATIC_EN with REPEAT_DELAY=100, REPEAT_RATE=20, A held -> first make, repeat at +100 clocks, then every 20 clocks. Releasing A -> break event and repeats stop.
